// File: rtl/spi_master_shift.sv
// SPI master shift engine: serialises a WIDTH-bit word on MOSI and collects MISO into rx_data.
// The SPI mode (CPOL/CPHA) is latched per frame when start is accepted.
//
// state | meaning
// IDLE  | CS_n high, SCLK tracks CPOL of SelectMode, waiting for start
// SETUP | CS_n low, CLK_DIV cycles before the first SCLK edge
// XFER  | 2*WIDTH SCLK edges, one every CLK_DIV cycles
// HOLD  | CLK_DIV cycles after the last edge, then done and release CS_n

module spi_master_shift #(
    parameter int WIDTH   = 16,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [1:0]       SelectMode,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             start,
    input  logic             MISO,
    output logic             SCLK,
    output logic             MOSI,
    output logic             CS_n,
    output logic [WIDTH-1:0] rx_data,
    output logic             busy,
    output logic             done
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EW = $clog2(2 * WIDTH + 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [EW-1:0] EDGE_LAST = EW'(2 * WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_XFER  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [DW-1:0]    div_cnt_q, div_cnt_d;
    logic [EW-1:0]    edge_cnt_q, edge_cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             cs_n_q, cs_n_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic div_tc;
    logic leading;
    logic last_edge;

    assign div_tc    = (div_cnt_q == DIV_LAST);
    assign leading   = ~edge_cnt_q[0];
    assign last_edge = (edge_cnt_q == EDGE_LAST);

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        edge_cnt_d = edge_cnt_q;
        mode_d     = mode_q;
        tx_d       = tx_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                sclk_d     = SelectMode[1];
                cs_n_d     = 1'b1;
                busy_d     = 1'b0;
                div_cnt_d  = '0;
                edge_cnt_d = '0;
                if (start) begin
                    state_d = ST_SETUP;
                    mode_d  = SelectMode;
                    tx_d    = tx_data;
                    rx_sr_d = '0;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    if (!SelectMode[0]) begin
                        mosi_d = tx_data[WIDTH-1];
                    end
                end
            end
            ST_SETUP: begin
                sclk_d = mode_q[1];
                if (div_tc) begin
                    div_cnt_d = '0;
                    state_d   = ST_XFER;
                end else begin
                    div_cnt_d = div_cnt_q + DW'(1);
                end
            end
            ST_XFER: begin
                if (div_tc) begin
                    div_cnt_d  = '0;
                    sclk_d     = ~sclk_q;
                    edge_cnt_d = edge_cnt_q + EW'(1);
                    // CPHA=0 samples on leading edges, CPHA=1 on trailing; the other edge shifts
                    if (leading ^ mode_q[0]) begin
                        rx_sr_d = {rx_sr_q[WIDTH-2:0], MISO};
                    end else if (mode_q[0] || !last_edge) begin
                        mosi_d = mode_q[0] ? tx_q[WIDTH-1] : tx_q[WIDTH-2];
                        tx_d   = tx_q << 1;
                    end
                    if (last_edge) begin
                        state_d = ST_HOLD;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DW'(1);
                end
            end
            default: begin
                sclk_d = mode_q[1];
                if (div_tc) begin
                    div_cnt_d = '0;
                    state_d   = ST_IDLE;
                    cs_n_d    = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    rx_data_d = rx_sr_q;
                end else begin
                    div_cnt_d = div_cnt_q + DW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            div_cnt_q  <= '0;
            edge_cnt_q <= '0;
            mode_q     <= '0;
            tx_q       <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            mode_q     <= mode_d;
            tx_q       <= tx_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign SCLK    = sclk_q;
    assign MOSI    = mosi_q;
    assign CS_n    = cs_n_q;
    assign rx_data = rx_data_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_spi_master_shift.sv
// Bench for spi_master_shift: a cycle-count based frame model plus a bit-level slave,
// directed scenarios and randomized frames.

module tb_spi_master_shift;

    localparam int W     = 16;
    localparam int D     = 4;
    localparam int FRAME = (2 * W + 2) * D;

    logic         clk = 1'b0;
    logic         Reset;
    logic [1:0]   SelectMode;
    logic [W-1:0] tx_data;
    logic         start;
    logic         MISO;
    logic         SCLK, MOSI, CS_n, busy, done;
    logic [W-1:0] rx_data;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // slave side
    bit           lp_en = 1'b0;
    logic [1:0]   s_mode = 2'd0;
    logic [W-1:0] s_word = '0;
    logic         slave_miso = 1'b0;
    logic         s_prev = 1'b0;
    int           s_cnt = 0;

    assign MISO = lp_en ? MOSI : slave_miso;

    spi_master_shift #(.WIDTH(W), .CLK_DIV(D)) dut (
        .clk       (clk),
        .Reset     (Reset),
        .SelectMode(SelectMode),
        .tx_data   (tx_data),
        .start     (start),
        .MISO      (MISO),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .CS_n      (CS_n),
        .rx_data   (rx_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Slave: counts SCLK toggles since CS_n fell and presents the bit for the next sample edge.
    always @(negedge clk) begin
        int b;
        if (CS_n) begin
            s_cnt  = 0;
            s_prev = SCLK;
        end else if (SCLK !== s_prev) begin
            s_cnt++;
            s_prev = SCLK;
        end
        if (!s_mode[0]) b = s_cnt / 2;
        else            b = (s_cnt == 0) ? 0 : (s_cnt + 1) / 2 - 1;
        if (b > W - 1) b = W - 1;
        slave_miso = s_word[W-1-b];
    end

    // Frame model: outputs derived from the number of clk edges since the accepting edge.
    bit           act = 1'b0;
    int           n = 0;
    int           k, b;
    logic [1:0]   lm;
    logic [W-1:0] ltx, lsr;
    logic         m_sclk, m_mosi, m_cs, m_busy, m_done;
    logic [W-1:0] m_rx;

    always @(posedge clk) begin
        m_done = 1'b0;
        if (Reset) begin
            act = 1'b0; m_sclk = 1'b0; m_mosi = 1'b0; m_cs = 1'b1; m_busy = 1'b0; m_rx = '0;
        end else if (!act) begin
            m_sclk = SelectMode[1]; m_cs = 1'b1; m_busy = 1'b0;
            if (start) begin
                act = 1'b1; n = 0; lm = SelectMode; ltx = tx_data; lsr = '0;
                m_cs = 1'b0; m_busy = 1'b1;
                if (!SelectMode[0]) m_mosi = tx_data[W-1];
            end
        end else begin
            n++;
            if (n == FRAME) begin
                act = 1'b0; m_done = 1'b1; m_cs = 1'b1; m_busy = 1'b0; m_rx = lsr; m_sclk = lm[1];
            end else begin
                k = (n < 2 * D) ? 0 : n / D - 1;
                m_sclk = lm[1] ^ k[0];
                if (n >= 2 * D && n % D == 0 && ((k % 2 == 1) != lm[0]))
                    lsr = {lsr[W-2:0], MISO};
                if (!lm[0]) begin
                    b = k / 2;
                    if (b > W - 1) b = W - 1;
                    m_mosi = ltx[W-1-b];
                end else if (k >= 1) begin
                    m_mosi = ltx[W-(k+1)/2];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("sclk", 32'(SCLK), 32'(m_sclk));
            chk("mosi", 32'(MOSI), 32'(m_mosi));
            chk("cs_n", 32'(CS_n), 32'(m_cs));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("rx_data", 32'(rx_data), 32'(m_rx));
        end
    end

    task automatic run_frame(input logic [1:0] md, input logic [W-1:0] tx, input logic [W-1:0] sw,
                             input bit lp, input int poke_at,
                             output int lat, output int cs_low, output int ndone,
                             output int rises, output int bad_mosi);
        logic ps, pm;
        s_mode = md; s_word = sw; lp_en = lp;
        @(negedge clk);
        SelectMode = md; tx_data = tx; start = 1'b1;
        lat = 0; cs_low = 0; ndone = 0; rises = 0; bad_mosi = 0;
        ps = SCLK; pm = MOSI;
        for (int c = 0; c < FRAME + 40; c++) begin
            @(negedge clk);
            if (c == 0) start = 1'b0;
            if (c == poke_at) begin
                start = 1'b1; SelectMode = ~md; tx_data = ~tx;
            end
            if (c == poke_at + 1) start = 1'b0;
            if (done) begin
                ndone++;
                if (ndone == 1) lat = c;
            end
            if (!CS_n) cs_low++;
            if (SCLK && !ps) rises++;
            if (MOSI !== pm && !(ps && !SCLK)) bad_mosi++;
            ps = SCLK; pm = MOSI;
            if (ndone != 0 && c >= lat + 3) break;
        end
    endtask

    initial begin
        int lat, csl, nd, ri, bm, tog, dn, hi_len, runs;
        logic [1:0] md;
        logic [W-1:0] tx, sw;
        logic prev;

        Reset = 1'b1; start = 1'b0; SelectMode = 2'd0; tx_data = '0;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_sclk", 32'(SCLK), 32'd0);
        chk("rst_cs_n", 32'(CS_n), 32'd1);
        chk("rst_mosi", 32'(MOSI), 32'd0);
        chk("rst_rx", 32'(rx_data), 32'd0);
        Reset = 1'b0;
        repeat (3) @(negedge clk);

        // mode 0, loopback
        run_frame(2'd0, 16'hA5C3, '0, 1'b1, -1, lat, csl, nd, ri, bm);
        chk("t1_latency", 32'(lat), 32'd136);
        chk("t1_rx", 32'(rx_data), 32'h0000A5C3);
        chk("t1_model_rx", 32'(m_rx), 32'h0000A5C3);
        chk("t1_rises", 32'(ri), 32'd16);
        chk("t1_cs_low", 32'(csl), 32'd136);
        lp_en = 1'b0;

        // mode 3, MISO high
        run_frame(2'd3, 16'h8001, 16'hFFFF, 1'b0, -1, lat, csl, nd, ri, bm);
        chk("t2_rx", 32'(rx_data), 32'h0000FFFF);
        chk("t2_mosi_on_fall", 32'(bm), 32'd0);
        chk("t2_sclk_idle", 32'(SCLK), 32'd1);

        // modes 1 and 2
        run_frame(2'd1, 16'h0F0F, 16'h1234, 1'b0, -1, lat, csl, nd, ri, bm);
        chk("t3_m1_rx", 32'(rx_data), 32'h00001234);
        chk("t3_m1_cs_low", 32'(csl), 32'd136);
        run_frame(2'd2, 16'hF0F0, 16'h1234, 1'b0, -1, lat, csl, nd, ri, bm);
        chk("t3_m2_rx", 32'(rx_data), 32'h00001234);
        chk("t3_m2_cs_low", 32'(csl), 32'd136);

        // start and mode change while busy
        run_frame(2'd0, 16'h3C5A, 16'hBEEF, 1'b0, 10, lat, csl, nd, ri, bm);
        chk("t4_ndone", 32'(nd), 32'd1);
        chk("t4_rx", 32'(rx_data), 32'h0000BEEF);
        chk("t4_latency", 32'(lat), 32'd136);

        // reset at the 8th SCLK edge
        s_mode = 2'd2; s_word = 16'h5A5A;
        @(negedge clk);
        SelectMode = 2'd2; tx_data = 16'h1111; start = 1'b1;
        tog = 0; prev = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (c == 0) begin
                start = 1'b0; prev = SCLK;
            end else begin
                if (SCLK !== prev) tog++;
                prev = SCLK;
                if (tog == 8) break;
            end
        end
        chk("t5_reach_edge8", 32'(tog), 32'd8);
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        chk("t5_cs_n", 32'(CS_n), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_sclk", 32'(SCLK), 32'd0);
        chk("t5_rx", 32'(rx_data), 32'd0);
        dn = 0;
        repeat (150) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("t5_no_done", 32'(dn), 32'd0);
        run_frame(2'd2, 16'h2468, 16'hC0DE, 1'b0, -1, lat, csl, nd, ri, bm);
        chk("t5_after_rx", 32'(rx_data), 32'h0000C0DE);
        chk("t5_after_lat", 32'(lat), 32'd136);

        // start held high: back-to-back frames
        s_mode = 2'd1; s_word = 16'h9C3E;
        @(negedge clk);
        SelectMode = 2'd1; tx_data = 16'h7E81; start = 1'b1;
        nd = 0; hi_len = 0; runs = 0;
        for (int c = 0; c <= 3 * (FRAME + 1) - 1; c++) begin
            @(negedge clk);
            if (done) nd++;
            if (CS_n) hi_len++;
            else begin
                if (hi_len > 0) begin
                    runs++;
                    chk("t6_cs_gap", 32'(hi_len), 32'd1);
                end
                hi_len = 0;
            end
            if (c == 3 * (FRAME + 1) - 1) start = 1'b0;
        end
        chk("t6_ndone", 32'(nd), 32'd3);
        chk("t6_gaps", 32'(runs), 32'd2);
        chk("t6_rx", 32'(rx_data), 32'h00009C3E);
        repeat (5) @(negedge clk);

        // randomized frames
        for (int i = 0; i < 6; i++) begin
            md = 2'($urandom_range(0, 3));
            tx = W'($urandom);
            sw = W'($urandom);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_frame(md, tx, sw, 1'b0, -1, lat, csl, nd, ri, bm);
            chk("rand_rx", 32'(rx_data), 32'(sw));
            chk("rand_lat", 32'(lat), 32'(FRAME));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
